rst_seq_gen: RTL and testbench

Reset source for the synchronous-reset flops throughout the design. Accepts the chip-level asynchronous reset, a raw push-button and a software reset request, and drives NDOM synchronous active-high reset lines. The lines are held for a minimum time, then released one domain at a time in a fixed order, with a `ready` flag once every domain is out of reset. Downstream flops sample `srst[k]` as their synchronous reset input.

---
 rtl/rst_seq_gen.sv | 121 ++++++++++++
 tb/tb_rst_seq_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_gen.sv
// rtl/rst_seq_gen.sv - staged synchronous reset generator with debounced button and software request
// Holds all domains in reset, then releases them one by one; any request restarts the sequence.
module rst_seq_gen #(
  parameter int DEBOUNCE = 16,
  parameter int HOLD     = 8,
  parameter int NDOM     = 3,
  parameter int STAGGER  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            btn,
  input  logic            sw_req,
  output logic [NDOM-1:0] srst,
  output logic            ready
);

  localparam int MAXHS = (HOLD > STAGGER) ? HOLD : STAGGER;
  localparam int MAXC  = (MAXHS > DEBOUNCE) ? MAXHS : DEBOUNCE;
  localparam int CW    = ($clog2(MAXC) > 0) ? $clog2(MAXC) : 1;
  localparam int IW    = (NDOM > 1) ? $clog2(NDOM) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;

  logic          s1;
  logic          s2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] dcnt;
  logic          req;

  // btn is asynchronous: only s2 feeds the debouncer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      dcnt     <= '0;
    end else begin
      s1       <= btn;
      s2       <= s1;
      stable_d <= stable;
      if (s2 == stable) begin
        dcnt <= '0;
      end else if (dcnt == DEB_LAST) begin
        stable <= s2;
        dcnt   <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  // only the press edge of the debounced level counts; release is ignored
  assign req = (stable & ~stable_d) | sw_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_HOLD;
      cnt   <= '0;
      idx   <= '0;
      srst  <= '1;
      ready <= 1'b0;
    end else if (req) begin
      state <= ST_HOLD;
      cnt   <= '0;
      idx   <= '0;
      srst  <= '1;
      ready <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt     <= '0;
            idx     <= '0;
            srst[0] <= 1'b0;
            if (NDOM == 1) begin
              state <= ST_RUN;
              ready <= 1'b1;
            end else begin
              state <= ST_RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt == STAG_LAST) begin
            cnt <= '0;
            idx <= idx + 1'b1;
            for (int k = 0; k < NDOM; k++) begin
              if (k == int'(idx) + 1) srst[k] <= 1'b0;
            end
            if (int'(idx) + 2 == NDOM) begin
              state <= ST_RUN;
              ready <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_gen.sv
// tb/tb_rst_seq_gen.sv - self-checking bench for rst_seq_gen
// Reference tracks edges since the last reset cause and derives the release schedule arithmetically.
module tb_rst_seq_gen;

  localparam int DEBOUNCE = 16;
  localparam int HOLD     = 8;
  localparam int NDOM     = 3;
  localparam int STAGGER  = 4;

  logic            clk    = 1'b0;
  logic            reset  = 1'b1;
  logic            btn    = 1'b0;
  logic            sw_req = 1'b0;
  logic [NDOM-1:0] srst;
  logic            ready;

  int checks = 0;
  int errors = 0;

  bit m_s1, m_s2, m_stable, m_stable_d, m_req;
  int m_diff, m_since, edge_n;

  rst_seq_gen #(
    .DEBOUNCE(DEBOUNCE),
    .HOLD    (HOLD),
    .NDOM    (NDOM),
    .STAGGER (STAGGER)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .sw_req(sw_req),
    .srst  (srst),
    .ready (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  function automatic logic [NDOM-1:0] exp_srst(input int since);
    logic [NDOM-1:0] v;
    for (int k = 0; k < NDOM; k++) v[k] = (since < HOLD + k * STAGGER);
    return v;
  endfunction

  function automatic logic exp_ready(input int since);
    return since >= HOLD + (NDOM - 1) * STAGGER;
  endfunction

  // reference: a domain is out of reset once enough edges have passed since the last cause
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_s1 = 0; m_s2 = 0; m_stable = 0; m_stable_d = 0;
        m_diff = 0; m_since = 0; edge_n = 0;
      end else begin
        m_req   = (m_stable && !m_stable_d) || sw_req;
        m_since = m_req ? 0 : ((m_since < 1000) ? m_since + 1 : m_since);
        m_stable_d = m_stable;
        m_diff = (m_s2 != m_stable) ? m_diff + 1 : 0;
        if (m_diff == DEBOUNCE) begin
          m_stable = m_s2;
          m_diff   = 0;
        end
        m_s2 = m_s1;
        m_s1 = btn;
        edge_n++;
      end
      #1;
      check("model_srst", srst, exp_srst(m_since));
      check("model_ready", ready, exp_ready(m_since));
    end
  end

  task automatic at_edge(input int e);
    int guard;
    guard = 0;
    while (edge_n < e && guard < 300) begin
      @(posedge clk);
      #2;
      guard++;
    end
    check("edge_reach", edge_n, e);
  endtask

  task automatic pulse_sw(output int t);
    @(negedge clk);
    sw_req = 1'b1;
    t = edge_n + 1;
    @(negedge clk);
    sw_req = 1'b0;
  endtask

  int t, u, v, seg;

  initial begin
    // power-up
    repeat (3) @(posedge clk);
    #2;
    check("por_srst", srst, 3'b111);
    check("por_ready", ready, 0);
    @(negedge clk);
    reset = 1'b0;
    at_edge(7);  check("pu7_srst", srst, 3'b111);
    at_edge(8);  check("pu8_srst", srst, 3'b110);
    at_edge(12); check("pu12_srst", srst, 3'b100); check("pu12_ready", ready, 0);
    at_edge(16); check("pu16_srst", srst, 3'b000); check("pu16_ready", ready, 1);

    // software request from RUN
    at_edge(20);
    pulse_sw(t);
    at_edge(t);      check("sw_srst", srst, 3'b111); check("sw_ready", ready, 0);
    at_edge(t + 7);  check("sw7_srst", srst, 3'b111);
    at_edge(t + 8);  check("sw8_srst", srst, 3'b110);
    at_edge(t + 12); check("sw12_srst", srst, 3'b100);
    at_edge(t + 16); check("sw16_srst", srst, 3'b000); check("sw16_ready", ready, 1);

    // bouncing button
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i % 3 == 0) btn = ~btn;
    end
    @(negedge clk);
    btn = 1'b0;
    repeat (30) @(negedge clk);
    check("bounce_srst", srst, 3'b000);
    check("bounce_ready", ready, 1);

    // clean press, then release
    @(negedge clk);
    btn = 1'b1;
    t = edge_n + 1;
    at_edge(t + 17); check("btn17_srst", srst, 3'b000);
    at_edge(t + 18); check("btn18_srst", srst, 3'b111); check("btn18_ready", ready, 0);
    at_edge(t + 29);
    @(negedge clk);
    btn = 1'b0;
    at_edge(t + 70); check("btnrel_srst", srst, 3'b000); check("btnrel_ready", ready, 1);

    // request during RELEASE
    pulse_sw(t);
    at_edge(t + 9); check("rel_pre_srst", srst, 3'b110);
    pulse_sw(u);
    at_edge(u);      check("rel_req_srst", srst, 3'b111);
    at_edge(u + 8);  check("rel8_srst", srst, 3'b110);
    at_edge(u + 12); check("rel12_srst", srst, 3'b100);
    at_edge(u + 16); check("rel16_srst", srst, 3'b000); check("rel16_ready", ready, 1);

    // asynchronous reset mid-release
    pulse_sw(v);
    at_edge(v + 13); check("ar_pre_srst", srst, 3'b100);
    #1 reset = 1'b1;
    #1;
    check("ar_srst", srst, 3'b111);
    check("ar_ready", ready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    at_edge(7);  check("ar7_srst", srst, 3'b111);
    at_edge(8);  check("ar8_srst", srst, 3'b110);
    at_edge(12); check("ar12_srst", srst, 3'b100);
    at_edge(16); check("ar16_srst", srst, 3'b000); check("ar16_ready", ready, 1);

    // randomized button segments and sparse software requests
    seg = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      sw_req = ($urandom_range(0, 199) < 2);
      if (seg == 0) begin
        btn = ~btn;
        seg = ($urandom_range(0, 3) == 0) ? $urandom_range(17, 60) : $urandom_range(1, 15);
      end else begin
        seg--;
      end
    end
    @(negedge clk);
    sw_req = 1'b0;
    btn    = 1'b0;
    repeat (60) @(negedge clk);
    check("final_srst", srst, 3'b000);
    check("final_ready", ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
